axis_dwidth_upsizer: RTL and testbench
======================================

Name: axis_dwidth_upsizer

Overview:
- AXI4-Stream width converter, narrow to wide: packs NUM_REG consecutive WIDTH-bit slave beats into one WIDTH*NUM_REG-bit master beat.
- Companion to axis_dwidth_downsizer. Uses the same slot ordering, so a downsizer→upsizer chain is transparent.
- Slot 0 (first narrow beat) occupies bits [WIDTH-1:0].
- An early s_axis_tlast flushes a partial wide beat. m_axis_tkeep marks which slots are valid.

Parameters:
- WIDTH, 32: narrow (slave) data width in bits.
- NUM_REG, 2: narrow beats per wide beat. Legal range ≥2.

Ports:
- aclk  in  1  clock; all state on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  narrow beat valid.
- s_axis_tready  out  1  narrow beat accepted when tvalid&&tready.
- s_axis_tdata  in  WIDTH  narrow data.
- s_axis_tlast  in  1  last narrow beat of packet.
- m_axis_tvalid  out  1  wide beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  WIDTH*NUM_REG  wide data, slot k at bits [k*WIDTH +: WIDTH].
- m_axis_tkeep  out  NUM_REG  per-slot valid; bit k set ⇒ slot k holds real data.
- m_axis_tlast  out  1  wide beat contains the packet's last narrow beat.

Behaviour:
- Reset (aresetn low, asynchronous):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
  - Slot index=0, accumulator=0.
  - s_axis_tready=0 while aresetn low.
- Reset mid-packet discards any partial accumulation and any unsent wide beat. Nothing is emitted for them after release.
- State:
  - Accumulator acc[NUM_REG-1:0][WIDTH]; valid slots acc_keep.
  - Slot index idx, range 0..NUM_REG-1.
  - Output register: m_axis_* outputs are registered, never combinational from s_axis.
- s_axis_tready = aresetn && (!m_axis_tvalid || m_axis_tready).
  - Combinational from m_axis_tready.
  - Stalls narrow input only when the output register is full and not draining.
- On accepted narrow beat, with idx<NUM_REG-1 and tlast=0: write acc[idx], set acc_keep[idx], idx++.
- On accepted narrow beat, with idx==NUM_REG-1 or tlast=1 (completion):
  - Next cycle: m_axis_tdata = acc with slot idx replaced by s_axis_tdata; unfilled slots forced to 0.
  - m_axis_tkeep = acc_keep | (1<<idx).
  - m_axis_tlast = s_axis_tlast; m_axis_tvalid=1.
  - Clear acc, acc_keep and idx to 0.
- Latency: wide beat visible the cycle after its final narrow beat is accepted.
- Throughput: one narrow beat per cycle sustained when m_axis_tready=1.
- Output hold: while m_axis_tvalid && !m_axis_tready, m_axis_* are held stable (AXI rule).
  - Non-completing narrow beats are also blocked, since tready=0.
- Output clear: m_axis_tvalid drops the cycle after handshake unless a new completion happens in the same cycle.
  - Simultaneous m handshake + s completion: output register reloads back-to-back with no bubble.
- tlast on slot 0: single-slot wide beat, tkeep=...0001, upper slots 0.
- m_axis_tlast is never set without the accepted s_axis_tlast.
- tkeep is always contiguous from bit 0.
- s_axis_tdata is ignored unless tvalid&&tready. s_axis_tvalid may deassert between beats of a wide word; acc is held.

Decomposition:
- Package axis_width_pkg:
  - Default WIDTH/NUM_REG localparams.
  - Function for idx width: $clog2(NUM_REG), minimum 1.
  - Shared with axis_dwidth_downsizer.
- One natural sub-module: axis_out_reg.
  - Registered valid/ready output stage, parameterised on payload width.
  - Carries the {tdata,tkeep,tlast} payload.
  - Provides the load/hold/clear rule and the ready equation.
- Packing logic (acc, idx, completion) stays in axis_dwidth_upsizer.

Test Plan (WIDTH=32, NUM_REG=2):
- Full beats: narrow 0x00000064, 0x00000001 (no tlast), m_axis_tready=1 → one cycle after 2nd accept: tdata=0x00000001_00000064, tkeep=2'b11, tlast=0, 1 cycle valid.
- Streaming + tlast: 6 back-to-back beats 0..5 with tlast on beat 5 → wide beats 0x1_0, 0x3_2, 0x5_4; tlast only on the third; s_axis_tready stays 1 throughout.
- Odd packet: 3 beats 0xA,0xB,0xC, tlast on 0xC → beats 0x0000000B_0000000A (keep 11, last 0), 0x00000000_0000000C (keep 01, last 1).
- Back-pressure: m_axis_tready=0 for 5 cycles after a wide beat appears → m_axis_* stable.
  - s_axis_tready=0 from that point.
  - No data lost; output resumes in order on tready=1.
- Reset mid-operation: one narrow beat 0x11 accepted, then aresetn low 2 cycles → all outputs 0, s_axis_tready=0 during reset.
  - Next pair 0x22,0x33 yields 0x00000033_00000022 (no 0x11).
- Gapped input: s_axis_tvalid toggles every other cycle over 4 beats → same wide data as the ungapped case; no spurious m_axis_tvalid.

Source files
------------

// File: rtl/axis_width_pkg.sv
// axis_width_pkg: shared defaults and helpers for the AXI-Stream width converters
package axis_width_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NUM_REG = 2;
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: registered valid/ready output stage with load/hold/clear behaviour
module axis_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] payload,
    output logic         accept,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] q
);
    assign accept = rst_n && (!valid || ready);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load && accept) begin
            valid <= 1'b1;
            q     <= payload;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/axis_dwidth_upsizer.sv
// axis_dwidth_upsizer: packs NUM_REG narrow AXI-Stream beats into one wide beat, slot 0 in the low bits
module axis_dwidth_upsizer
    import axis_width_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REG = DEF_NUM_REG
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [WIDTH-1:0]         s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [WIDTH*NUM_REG-1:0] m_axis_tdata,
    output logic [NUM_REG-1:0]       m_axis_tkeep,
    output logic                     m_axis_tlast
);
    localparam int IW = idx_bits(NUM_REG);
    localparam int PW = WIDTH * NUM_REG + NUM_REG + 1;
    logic [NUM_REG-1:0][WIDTH-1:0] acc;
    logic [NUM_REG-1:0][WIDTH-1:0] wide;
    logic [NUM_REG-1:0]            acc_keep;
    logic [NUM_REG-1:0]            nxt_keep;
    logic [IW-1:0]                 idx;
    logic [PW-1:0]                 q;
    logic                          fire;
    logic                          done;
    assign fire = s_axis_tvalid && s_axis_tready;
    assign done = fire && (s_axis_tlast || idx == IW'(NUM_REG - 1));
    // Slots beyond the completing one are masked so a flushed partial beat carries zeros.
    always_comb begin
        nxt_keep = acc_keep | (NUM_REG'(1) << idx);
        for (int k = 0; k < NUM_REG; k++)
            wide[k] = nxt_keep[k] ? ((IW'(k) == idx) ? s_axis_tdata : acc[k]) : '0;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc      <= '0;
            acc_keep <= '0;
            idx      <= '0;
        end else if (done) begin
            acc      <= '0;
            acc_keep <= '0;
            idx      <= '0;
        end else if (fire) begin
            acc[idx]      <= s_axis_tdata;
            acc_keep[idx] <= 1'b1;
            idx           <= idx + IW'(1);
        end
    end
    axis_out_reg #(.W(PW)) u_out (
        .clk     (aclk),
        .rst_n   (aresetn),
        .load    (done),
        .payload ({wide, nxt_keep, s_axis_tlast}),
        .accept  (s_axis_tready),
        .valid   (m_axis_tvalid),
        .ready   (m_axis_tready),
        .q       (q)
    );
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = q;
endmodule

// File: tb/tb_axis_dwidth_upsizer.sv
// tb_axis_dwidth_upsizer: directed table, corner sequences and randomized model check of the upsizer
module tb_axis_dwidth_upsizer;
    localparam int W = 32;
    localparam int N = 2;
    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_valid, s_ready, s_last;
    logic [W-1:0]  s_data;
    logic          m_valid, m_ready, m_last;
    logic [W*N-1:0] m_data;
    logic [N-1:0]  m_keep;
    int n_chk = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    axis_dwidth_upsizer #(.WIDTH(W), .NUM_REG(N)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tdata  (s_data),
        .s_axis_tlast  (s_last),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tlast  (m_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        emit;
        logic [63:0] xd;
        logic [1:0]  xk;
        logic        xl;
    } vec_t;
    vec_t v[11];

    typedef struct {
        logic [63:0] d;
        logic [1:0]  k;
        logic        l;
    } wide_t;
    logic [31:0] part[$];
    wide_t       expq[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        wide_t w;
        wide_t e;
        v[0]  = '{32'h64, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0};
        v[1]  = '{32'h01, 1'b0, 1'b1, 64'h00000001_00000064, 2'b11, 1'b0};
        v[2]  = '{32'h00, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0};
        v[3]  = '{32'h01, 1'b0, 1'b1, 64'h00000001_00000000, 2'b11, 1'b0};
        v[4]  = '{32'h02, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0};
        v[5]  = '{32'h03, 1'b0, 1'b1, 64'h00000003_00000002, 2'b11, 1'b0};
        v[6]  = '{32'h04, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0};
        v[7]  = '{32'h05, 1'b1, 1'b1, 64'h00000005_00000004, 2'b11, 1'b1};
        v[8]  = '{32'h0A, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0};
        v[9]  = '{32'h0B, 1'b0, 1'b1, 64'h0000000B_0000000A, 2'b11, 1'b0};
        v[10] = '{32'h0C, 1'b1, 1'b1, 64'h00000000_0000000C, 2'b01, 1'b1};
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge aclk);
        check("rst_mvalid", 64'(m_valid), 64'd0);
        check("rst_mdata", m_data, 64'd0);
        check("rst_mkeep", 64'(m_keep), 64'd0);
        check("rst_mlast", 64'(m_last), 64'd0);
        check("rst_sready", 64'(s_ready), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_rst_sready", 64'(s_ready), 64'd1);

        s_valid = 1'b1; s_data = v[0].d; s_last = v[0].l;
        for (int i = 0; i < 11; i++) begin
            @(negedge aclk);
            check($sformatf("tbl%0d_mvalid", i), 64'(m_valid), 64'(v[i].emit));
            check($sformatf("tbl%0d_sready", i), 64'(s_ready), 64'd1);
            if (v[i].emit) begin
                check($sformatf("tbl%0d_mdata", i), m_data, v[i].xd);
                check($sformatf("tbl%0d_mkeep", i), 64'(m_keep), 64'(v[i].xk));
                check($sformatf("tbl%0d_mlast", i), 64'(m_last), 64'(v[i].xl));
            end
            if (i < 10) begin
                s_data = v[i+1].d; s_last = v[i+1].l;
            end else begin
                s_valid = 1'b0; s_last = 1'b0;
            end
        end
        @(negedge aclk);
        check("tbl_idle_mvalid", 64'(m_valid), 64'd0);

        m_ready = 1'b0; s_valid = 1'b1; s_data = 32'hA1;
        @(negedge aclk);
        s_data = 32'hA2;
        @(negedge aclk);
        s_data = 32'hA3;
        for (int i = 0; i < 5; i++) begin
            check("bp_mvalid", 64'(m_valid), 64'd1);
            check("bp_mdata", m_data, 64'h000000A2_000000A1);
            check("bp_mkeep", 64'(m_keep), 64'd3);
            check("bp_sready", 64'(s_ready), 64'd0);
            @(negedge aclk);
        end
        m_ready = 1'b1;
        #1 check("bp_release_sready", 64'(s_ready), 64'd1);
        @(negedge aclk);
        check("bp_after_drain_mvalid", 64'(m_valid), 64'd0);
        s_data = 32'hA4;
        @(negedge aclk);
        s_valid = 1'b0;
        check("bp_resume_mvalid", 64'(m_valid), 64'd1);
        check("bp_resume_mdata", m_data, 64'h000000A4_000000A3);
        @(negedge aclk);

        s_valid = 1'b1; s_data = 32'h11;
        @(negedge aclk);
        s_valid = 1'b0;
        aresetn = 1'b0;
        #1 check("mid_rst_sready", 64'(s_ready), 64'd0);
        @(negedge aclk);
        check("mid_rst_mvalid", 64'(m_valid), 64'd0);
        check("mid_rst_mdata", m_data, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        s_valid = 1'b1; s_data = 32'h22;
        @(negedge aclk);
        s_data = 32'h33;
        @(negedge aclk);
        s_valid = 1'b0;
        check("mid_rst_pair_mvalid", 64'(m_valid), 64'd1);
        check("mid_rst_pair_mdata", m_data, 64'h00000033_00000022);
        check("mid_rst_pair_mkeep", 64'(m_keep), 64'd3);
        @(negedge aclk);

        for (int i = 0; i < 8; i++) begin
            s_valid = (i % 2 == 0);
            s_data = (i % 2 == 0) ? 32'(i / 2 + 1) : 32'hDEADBEEF;
            @(negedge aclk);
            check($sformatf("gap%0d_mvalid", i), 64'(m_valid), 64'(i == 2 || i == 6));
            if (i == 2) check("gap_mdata0", m_data, 64'h00000002_00000001);
            if (i == 6) check("gap_mdata1", m_data, 64'h00000004_00000003);
        end
        s_valid = 1'b0;
        @(negedge aclk);

        for (int c = 0; c < 3000 + 30; c++) begin
            @(negedge aclk);
            if (c < 3000) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = $urandom;
                s_last  = ($urandom_range(0, 4) == 0);
                m_ready = ($urandom_range(0, 3) != 0);
            end else begin
                s_valid = 1'b0;
                m_ready = 1'b1;
            end
            #1;
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    check("rnd_spurious_beat", 64'd1, 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("rnd_mdata", m_data, e.d);
                    check("rnd_mkeep", 64'(m_keep), 64'(e.k));
                    check("rnd_mlast", 64'(m_last), 64'(e.l));
                end
            end
            if (s_valid && s_ready) begin
                part.push_back(s_data);
                if (part.size() == N || s_last) begin
                    w.d = '0; w.k = '0; w.l = s_last;
                    for (int k = 0; k < part.size(); k++) begin
                        w.d[k*W +: W] = part[k];
                        w.k[k] = 1'b1;
                    end
                    expq.push_back(w);
                    part.delete();
                end
            end
        end
        check("rnd_drain_empty", 64'(expq.size()), 64'd0);
        check("rnd_drain_mvalid", 64'(m_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
